// File: rtl/ym_frame_player_pkg.sv
// ym_bus_pkg: shared state/phase types and PSG bus encodings for the frame player
package ym_bus_pkg;
  typedef enum logic [1:0] {LOAD, READY, PLAY} state_e;
  typedef enum logic [1:0] {ADDR, GAP1, DATA, GAP2} phase_e;
  localparam logic [3:0] ENV_SHAPE_REG = 4'd13;
  localparam logic [7:0] ENV_SKIP_VAL = 8'hFF;
  localparam logic [1:0] LATCH = 2'b11;
  localparam logic [1:0] WRITE = 2'b10;
  localparam logic [1:0] INACTIVE = 2'b00;
  localparam logic [1:0] ADDR_GAP = 2'b01;
endpackage

// File: rtl/ym_frame_player_if.sv
// ym_frame_player_if: stream-in and PSG bus signals
//   stream: S_VALID/S_DATA in, S_READY out; control: CE, FRAME_TICK in
//   PSG: BDIR, BC, DO out; status: BUSY, UNDERRUN out
interface ym_frame_player_if;
  logic CE, FRAME_TICK, S_VALID, S_READY, BDIR, BC, BUSY, UNDERRUN;
  logic [7:0] S_DATA, DO;
  modport master(input CE, FRAME_TICK, S_VALID, S_DATA, output S_READY, BDIR, BC, DO, BUSY, UNDERRUN);
  modport slave(output CE, FRAME_TICK, S_VALID, S_DATA, input S_READY, BDIR, BC, DO, BUSY, UNDERRUN);
endinterface

// File: rtl/ym_frame_player_bus_cycle.sv
// ym_bus_cycle: one PSG register write as ADDR/GAP1/DATA/GAP2 phases of HOLD CE ticks
//   in: CLK, RESET, start, addr, data, CE; out: BDIR, BC, DO (registered), done
module ym_bus_cycle
  import ym_bus_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [3:0] addr,
  input  logic [7:0] data,
  input  logic       CE,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  output logic       done
);
  localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
  logic active_q, active_d, adv;
  phase_e phase_q, phase_d, step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] bus_q, bus_d;
  logic [7:0] do_q, do_d;
  // done is combinational so the next register's start lands on the same edge
  always_comb begin
    adv = active_q && CE && cnt_q == '0;
    step = phase_q == ADDR ? GAP1 : phase_q == GAP1 ? DATA : phase_q == DATA ? GAP2 : ADDR;
    done = adv && phase_q == GAP2;
    active_d = start || (active_q && !done);
    phase_d = start ? ADDR : adv ? step : phase_q;
    cnt_d = (start || adv) ? CW'(HOLD - 1) : (active_q && CE) ? cnt_q - 1'b1 : cnt_q;
    bus_d = start ? LATCH : adv ? (step == GAP1 ? ADDR_GAP : step == DATA ? WRITE : INACTIVE) : bus_q;
    do_d = start ? {4'b0, addr} : (adv && step == DATA) ? data : do_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      active_q <= 1'b0;
      phase_q <= ADDR;
      cnt_q <= '0;
      bus_q <= INACTIVE;
      do_q <= '0;
    end else begin
      active_q <= active_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      bus_q <= bus_d;
      do_q <= do_d;
    end
  end
  assign {BDIR, BC} = bus_q;
  assign DO = do_q;
endmodule

// File: rtl/ym_frame_player.sv
// ym_frame_player: buffers one NREGS-byte register frame and replays it to the PSG per FRAME_TICK
//   in: CLK, RESET; bus (master): CE, FRAME_TICK, S_VALID, S_DATA in;
//   S_READY, BDIR, BC, DO, BUSY, UNDERRUN out (all registered)
module ym_frame_player
  import ym_bus_pkg::*;
#(
  parameter int NREGS = 14,
  parameter int HOLD = 2
) (
  input logic CLK,
  input logic RESET,
  ym_frame_player_if.master bus
);
  state_e state_q, state_d;
  logic [3:0] widx_q, widx_d, ridx_q, ridx_d;
  logic [7:0] frame_q [16];
  logic s_ready_q, busy_q, underrun_q, underrun_d;
  logic accept, last, tick_go, start, done, env_skip, more;
  logic [4:0] inc, nxt;
  // an R13 of 0xFF means "leave the envelope alone": no bus cycles for it
  assign env_skip = NREGS > 13 && frame_q[ENV_SHAPE_REG] == ENV_SKIP_VAL;
  always_comb begin
    accept = bus.S_VALID && state_q == LOAD;
    last = widx_q == 4'(NREGS - 1);
    inc = {1'b0, ridx_q} + 5'd1;
    nxt = (env_skip && inc == {1'b0, ENV_SHAPE_REG}) ? inc + 5'd1 : inc;
    more = nxt < 5'(NREGS);
    tick_go = bus.FRAME_TICK && (state_q == READY || (accept && last));
    start = tick_go || (state_q == PLAY && done && more);
    state_d = tick_go ? PLAY : (accept && last) ? READY : (state_q == PLAY && done && !more) ? LOAD : state_q;
    widx_d = accept ? (last ? 4'd0 : widx_q + 4'd1) : widx_q;
    ridx_d = tick_go ? 4'd0 : (state_q == PLAY && done && more) ? nxt[3:0] : ridx_q;
    underrun_d = bus.FRAME_TICK && !tick_go;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= LOAD;
      widx_q <= '0;
      ridx_q <= '0;
      s_ready_q <= 1'b1;
      busy_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q <= widx_d;
      ridx_q <= ridx_d;
      s_ready_q <= state_d == LOAD;
      busy_q <= state_d != LOAD;
      underrun_q <= underrun_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (accept) frame_q[widx_q] <= bus.S_DATA;
  end
  ym_bus_cycle #(.HOLD(HOLD)) u_cycle (
    .CLK(CLK),
    .RESET(RESET),
    .start(start),
    .addr(ridx_d),
    .data(frame_q[ridx_q]),
    .CE(bus.CE),
    .BDIR(bus.BDIR),
    .BC(bus.BC),
    .DO(bus.DO),
    .done(done)
  );
  assign bus.S_READY = s_ready_q;
  assign bus.BUSY = busy_q;
  assign bus.UNDERRUN = underrun_q;
endmodule

// File: tb/tb_ym_frame_player.sv
// tb_ym_frame_player: vector table, directed corner cases and random frames against a write-list model
module tb_ym_frame_player;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always #5 CLK = ~CLK;

  ym_frame_player_if i0();
  ym_frame_player_if i1();
  ym_frame_player #(.NREGS(14), .HOLD(2)) dut0 (.CLK(CLK), .RESET(RESET), .bus(i0));
  ym_frame_player #(.NREGS(14), .HOLD(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(i1));

  typedef struct packed {
    logic rst, v;
    logic [7:0] d;
    logic t, sr, bz, un, bd, bc;
    logic [7:0] dout;
  } vec_t;
  typedef struct packed {
    logic bd, bc;
    logic [7:0] d;
  } smp_t;

  vec_t tbl[$];
  smp_t tr[$];
  logic [7:0] fb [14];

  function automatic vec_t mk(int rst, int v, int d, int t, int sr, int bz, int un, int bd, int bc, int dout);
    return {1'(rst), 1'(v), 8'(d), 1'(t), 1'(sr), 1'(bz), 1'(un), 1'(bd), 1'(bc), 8'(dout)};
  endfunction

  function automatic smp_t rd_bus(int w);
    return w != 0 ? {i1.BDIR, i1.BC, i1.DO} : {i0.BDIR, i0.BC, i0.DO};
  endfunction
  function automatic int rd_sready(int w);
    return w != 0 ? int'(i1.S_READY) : int'(i0.S_READY);
  endfunction
  function automatic int rd_und(int w);
    return w != 0 ? int'(i1.UNDERRUN) : int'(i0.UNDERRUN);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    i1.CE = (cyc % 4 == 0);
  endtask

  task automatic drv(input int w, input int v, input logic [7:0] d, input int t);
    if (w != 0) begin
      i1.S_VALID = 1'(v); i1.S_DATA = d; i1.FRAME_TICK = 1'(t);
    end else begin
      i0.S_VALID = 1'(v); i0.S_DATA = d; i0.FRAME_TICK = 1'(t);
    end
  endtask

  task automatic load(input int w, input int tick_last);
    for (int k = 0; k < 14; k++) begin
      repeat ($urandom_range(0, 2)) step();
      for (int n = 0; n < 300 && rd_sready(w) == 0; n++) step();
      if (rd_sready(w) == 0) chk("load_ready", rd_sready(w), 1);
      drv(w, 1, fb[k], (tick_last != 0 && k == 13) ? 1 : 0);
      step();
      drv(w, 0, 8'h00, 0);
    end
  endtask

  task automatic capture(input int w, input int tick_at, output int cycles, output int unds);
    tr.delete();
    cycles = 0;
    unds = 0;
    while (rd_sready(w) == 0 && cycles < 1000) begin
      tr.push_back(rd_bus(w));
      unds += rd_und(w);
      cycles++;
      drv(w, 0, 8'h00, cycles == tick_at ? 1 : 0);
      step();
    end
    drv(w, 0, 8'h00, 0);
  endtask

  // model: the frame as an ordered list of (register, value) writes plus a fixed phase length
  task automatic check_frame(input int w, input string name, input int run, input int cycles, input int unds, input int exp_unds);
    logic [15:0] exp[$];
    logic [15:0] wr[$];
    logic [7:0] lat;
    smp_t cur, prev;
    int nl, unstable, badrun, len;
    for (int k = 0; k < 14; k++)
      if (!(k == 13 && fb[13] == 8'hFF)) exp.push_back({8'(k), fb[k]});
    lat = 8'hEE;
    nl = 0; unstable = 0; badrun = 0; len = 0;
    foreach (tr[i]) begin
      cur = tr[i];
      prev = i > 0 ? tr[i-1] : '0;
      if (cur.bd && !prev.bd) begin
        if (cur.bc) begin lat = cur.d; nl++; end
        else wr.push_back({lat, cur.d});
      end
      if (cur.bd && prev.bd && (cur.bc != prev.bc || cur.d != prev.d)) unstable++;
      if (i > 0 && {cur.bd, cur.bc} != {prev.bd, prev.bc}) begin
        if (len != run) badrun++;
        len = 0;
      end
      len++;
    end
    if (len != run) badrun++;
    chk({name, "_cycles"}, cycles, 4 * run * exp.size());
    chk({name, "_latches"}, nl, exp.size());
    chk({name, "_nwrites"}, wr.size(), exp.size());
    for (int i = 0; i < wr.size() && i < exp.size(); i++)
      chk($sformatf("%s_wr%0d", name, i), int'(wr[i]), int'(exp[i]));
    chk({name, "_unstable"}, unstable, 0);
    chk({name, "_phase_len"}, badrun, 0);
    chk({name, "_underruns"}, unds, exp_unds);
    chk({name, "_sready_end"}, rd_sready(w), 1);
  endtask

  task automatic play(input int w, input int tick_last, input int tick_at, input int run, input string name);
    int cycles, unds;
    load(w, tick_last);
    if (tick_last == 0) begin
      repeat ($urandom_range(0, 3)) step();
      if (w != 0) for (int n = 0; n < 4 && !i1.CE; n++) step();
      drv(w, 0, 8'h00, 1);
      step();
      drv(w, 0, 8'h00, 0);
    end
    capture(w, tick_at, cycles, unds);
    check_frame(w, name, run, cycles, unds, tick_at != 0 ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] lat;
    i0.CE = 1'b1; i1.CE = 1'b0;
    drv(0, 0, 8'h00, 0);
    drv(1, 0, 8'h00, 0);
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 1, k, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    for (int k = 5; k < 14; k++) tbl.push_back(mk(0, 1, k, 0, k < 13 ? 1 : 0, k == 13 ? 1 : 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    repeat (2) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    repeat (2) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    repeat (2) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 1, 1, 1));
    repeat (2) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    repeat (2) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    step();
    foreach (tbl[i]) begin
      RESET = tbl[i].rst;
      drv(0, int'(tbl[i].v), tbl[i].d, int'(tbl[i].t));
      step();
      chk($sformatf("vec%0d", i),
          int'({i0.S_READY, i0.BUSY, i0.UNDERRUN, i0.BDIR, i0.BC, i0.DO}),
          int'({tbl[i].sr, tbl[i].bz, tbl[i].un, tbl[i].bd, tbl[i].bc, tbl[i].dout}));
    end
    RESET = 1'b0;
    drv(0, 0, 8'h00, 0);
    n = 13;
    while (!i0.S_READY && n < 300) begin step(); n++; end
    chk("table_frame_len", n, 112);

    for (int k = 0; k < 14; k++) fb[k] = 8'(k);
    play(0, 0, 0, 2, "ramp");
    fb[13] = 8'hFF;
    play(0, 0, 0, 2, "skip");
    for (int k = 0; k < 14; k++) fb[k] = 8'($urandom_range(0, 254));
    play(0, 1, 20, 2, "ticklast");

    for (int k = 0; k < 14; k++) fb[k] = 8'($urandom_range(0, 254));
    load(0, 0);
    drv(0, 0, 8'h00, 1);
    step();
    drv(0, 0, 8'h00, 0);
    lat = 8'hEE;
    n = 0;
    while (!(i0.BDIR && !i0.BC && lat == 8'd5) && n < 300) begin
      if (i0.BDIR && i0.BC) lat = i0.DO;
      step();
      n++;
    end
    chk("rst_reached_r5_data", n < 300 ? 1 : 0, 1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("rst_bdir", int'(i0.BDIR), 0);
    chk("rst_sready", int'(i0.S_READY), 1);
    chk("rst_busy", int'(i0.BUSY), 0);
    for (int k = 0; k < 3; k++) begin drv(0, 1, 8'hA5, 0); step(); end
    drv(0, 0, 8'h00, 0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    for (int k = 0; k < 14; k++) fb[k] = 8'($urandom_range(0, 254));
    play(0, 0, 0, 2, "after_rst");

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 14; k++) fb[k] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) fb[13] = 8'hFF;
      play(0, 0, $urandom_range(0, 1) == 1 ? $urandom_range(2, 90) : 0, 2, $sformatf("rnd%0d", r));
    end

    for (int k = 0; k < 14; k++) fb[k] = 8'($urandom_range(0, 254));
    play(1, 0, 0, 4, "ce4");
    fb[13] = 8'hFF;
    play(1, 0, 0, 4, "ce4_skip");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
